branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
Parametrised branch predictor for the pipelined RISC-V core. It combines a direct-mapped BTB (valid/tag/target) with a separately indexed pattern history table (PHT) of saturating counters. An optional global history register (GHR) turns the PHT into gshare. N combinational lookup ports serve IF, for example PC+2 and PC+4 for compressed and normal fetch. One registered update port is driven from EX branch resolution, and performance counters track updates and mispredicts.

Parameters:
ENTRIES, 16, BTB and PHT depth; power of 2, minimum 2; IDX_W = log2(ENTRIES)
ADDR_W, 32, address/target width
CNT_W, 2, PHT counter width, 1..4
GHR_W, 0, global history bits; 0 = bimodal, otherwise 1..IDX_W
RD_PORTS, 2, number of lookup ports, 1..4

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
stall_i  in  1  pipeline stall (cache stall); suppresses update and counting
flush_i  in  1  invalidate all BTB entries (fence.i)
rd_addr_i  in  RD_PORTS*ADDR_W  lookup addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
rd_hit_o  out  RD_PORTS  predict taken with valid target, per port
rd_target_o  out  RD_PORTS*ADDR_W  predicted target, per port
upd_valid_i  in  1  resolved conditional branch this cycle
upd_addr_i  in  ADDR_W  branch address (same convention as lookup)
upd_target_i  in  ADDR_W  computed taken target
upd_taken_i  in  1  actual outcome
upd_mispredict_i  in  1  EX detected mispredict
ghr_o  out  max(GHR_W,1)  current history; 0 when GHR_W=0
upd_cnt_o  out  32  effective updates seen
miss_cnt_o  out  32  effective mispredicts seen

Behaviour:
- Reset (rst_n=0 at posedge): all valid=0, tags and targets=0. PHT counters = 2^(CNT_W-1)-1 (weakly not-taken). GHR=0, perf counters=0. As a result rd_hit_o=0 and rd_target_o=0 on the first cycle after reset. Reset asserted mid-update discards the update.
- Address split: idx = addr[IDX_W:1] (halfword granularity); tag = addr[ADDR_W-1:IDX_W+1].
- PHT index: pidx = idx XOR {zero-extend GHR} when GHR_W>0, otherwise idx.
- Lookup is purely combinational, zero latency, and all ports are independent.
  - rd_hit_o[k] = valid[idx] & (tag[idx]==tag_k) & PHT[pidx_k][CNT_W-1].
  - rd_target_o[k] = target[idx] whenever the tag matches; 0 otherwise.
- An effective update is eu = upd_valid_i & ~stall_i. It is applied at the posedge and visible to lookups the next cycle. A read in the same cycle sees the old value.
- BTB on eu:
  - taken & (miss or tag mismatch): allocate; valid=1, write tag and target (replaces the alias).
  - taken & tag hit: overwrite target.
  - not taken: BTB unchanged, no allocation.
- PHT on eu: PHT[pidx_upd] saturating +1 if taken, -1 if not. It does not wrap: max stays at 2^CNT_W-1, 0 stays at 0. The PHT updates even when the BTB misses.
- GHR on eu (GHR_W>0): GHR = {GHR[GHR_W-2:0], upd_taken_i}. Non-speculative, resolved outcomes only. The update's pidx uses the pre-shift GHR.
- Perf counters: upd_cnt_o += eu; miss_cnt_o += eu & upd_mispredict_i. Both saturate at 2^32-1.
- flush_i: all valid cleared at the posedge. If flush_i and eu occur together, the flush wins for the BTB (no allocation that cycle). PHT, GHR and counters still update. Flush is not gated by stall_i.
- stall_i held for multiple cycles with upd_valid_i=1 means exactly zero updates; the update is taken on the first unstalled cycle.
- Multiple read ports hitting the same index are permitted with no conflict.

Decomposition:
- Shared package bp_pkg: counter init/max constants, helpers f_idx, f_tag, f_sat_inc, f_sat_dec.
- One sub-module, bp_sat_counter_table: ENTRIES x CNT_W PHT with N combinational read ports and one saturating write port.
- BTB arrays, GHR and perf counters live in the top.

Test Plan:
- Reset: after rst_n low for 2 cycles, lookup 0x100 on both ports -> rd_hit_o=2'b00, rd_target_o=0, upd_cnt_o=0.
- Allocate and hit (CNT_W=2, GHR_W=0): update addr=0x104, target=0x200, taken=1. Next cycle, lookup 0x104 -> hit=1, target=0x200 (counter 1->2). A same-cycle lookup -> hit=0.
- Saturation: 5 taken then 1 not-taken at 0x104 -> still hit (counter 3->2). 3 more not-taken -> hit=0, counter pinned at 0 with no wrap.
- Alias: ENTRIES=16, allocate 0x104 taken, then 0x144 taken with target 0x300 (same idx, different tag). Lookup 0x104 -> hit=0; lookup 0x144 -> target 0x300.
- Stall and flush: upd_valid_i=1 with stall_i=1 for 3 cycles -> upd_cnt_o unchanged and no allocation. Flush together with a taken update -> lookup misses, but upd_cnt_o increments by 1.
- Gshare (GHR_W=2): taken, taken, not-taken updates -> ghr_o=2'b10. The following update indexes the PHT at idx XOR 2'b10, checked against a reference model.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch target predictor: BTB update operation
// encoding, PHT counter constants and the address split / saturating counter
// helpers. The helpers work on wide fixed-width values so that they can be
// shared by every parametrisation. Callers cast the result back to their own
// widths.
// -----------------------------------------------------------------------------
package bp_pkg;

  // What the BTB arrays do at the next clock edge.
  typedef enum logic [1:0] {
    BTB_HOLD  = 2'd0,
    BTB_FLUSH = 2'd1,
    BTB_WRITE = 2'd2
  } btb_op_e;

  // Index uses halfword granularity: addr[idx_w:1].
  function automatic logic [63:0] f_idx(input logic [63:0] addr, input int idx_w);
    return (addr >> 1) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag is everything above the index: addr[ADDR_W-1:idx_w+1].
  function automatic logic [63:0] f_tag(input logic [63:0] addr, input int idx_w);
    return addr >> (idx_w + 1);
  endfunction

  // Weakly not-taken reset value: 2^(cnt_w-1)-1.
  function automatic logic [3:0] f_cnt_init(input int cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  // Strongly taken ceiling: 2^cnt_w-1.
  function automatic logic [3:0] f_cnt_max(input int cnt_w);
    return 4'((1 << cnt_w) - 1);
  endfunction

  function automatic logic [3:0] f_sat_inc(input logic [3:0] v, input int cnt_w);
    return (v == f_cnt_max(cnt_w)) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] f_sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// -----------------------------------------------------------------------------
// bp_sat_counter_table
// ENTRIES x CNT_W pattern history table of saturating counters.
//   clk, rst_n  : clock, synchronous active-low reset (counters -> weakly NT)
//   rd_idx      : RD_PORTS packed indices, port k at [k*IDX_W +: IDX_W]
//   rd_taken    : per-port prediction (counter MSB), combinational
//   we          : apply one update at the clock edge
//   wr_idx      : counter to update
//   wr_taken    : saturating +1 when 1, saturating -1 when 0
// -----------------------------------------------------------------------------
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int CNT_W    = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [RD_PORTS*$clog2(ENTRIES)-1:0] rd_idx,
  output logic [RD_PORTS-1:0]         rd_taken,
  input  logic                        we,
  input  logic [$clog2(ENTRIES)-1:0]  wr_idx,
  input  logic                        wr_taken
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [CNT_W-1:0] cnt [ENTRIES];

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    assign rd_taken[k] = cnt[rd_idx[k*IDX_W +: IDX_W]][CNT_W-1];
  end

  // NOTE: this table is reset element by element because every counter must
  // start weakly not-taken; a plain RAM macro would lose that guarantee.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt[i] <= CNT_W'(f_cnt_init(CNT_W));
      end
    end else if (we) begin
      if (wr_taken) begin
        cnt[wr_idx] <= CNT_W'(f_sat_inc(4'(cnt[wr_idx]), CNT_W));
      end else begin
        cnt[wr_idx] <= CNT_W'(f_sat_dec(4'(cnt[wr_idx])));
      end
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped BTB (valid/tag/target) plus a PHT of saturating counters,
// optionally gshare-indexed through a global history register.
//   clk, rst_n       : clock, synchronous active-low reset
//   stall_i          : blocks the update port and perf counting
//   flush_i          : clears every BTB valid bit (not gated by stall)
//   rd_addr_i        : RD_PORTS packed lookup addresses
//   rd_hit_o         : per-port predict-taken with a valid target
//   rd_target_o      : per-port predicted target (0 without a tag match)
//   upd_*_i          : resolved conditional branch from EX
//   ghr_o            : current global history (0 in bimodal mode)
//   upd_cnt_o        : effective updates, saturating
//   miss_cnt_o       : effective mispredicts, saturating
// -----------------------------------------------------------------------------
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int ADDR_W   = 32,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 0,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall_i,
  input  logic                         flush_i,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr_i,
  output logic [RD_PORTS-1:0]          rd_hit_o,
  output logic [RD_PORTS*ADDR_W-1:0]   rd_target_o,
  input  logic                         upd_valid_i,
  input  logic [ADDR_W-1:0]            upd_addr_i,
  input  logic [ADDR_W-1:0]            upd_target_i,
  input  logic                         upd_taken_i,
  input  logic                         upd_mispredict_i,
  output logic [((GHR_W > 0) ? GHR_W : 1)-1:0] ghr_o,
  output logic [31:0]                  upd_cnt_o,
  output logic [31:0]                  miss_cnt_o
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_W  = ADDR_W - IDX_W - 1;
  localparam int GHR_OW = (GHR_W > 0) ? GHR_W : 1;

  // BTB storage
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]  target_mem [ENTRIES];

  logic [GHR_OW-1:0]  ghr;
  logic [IDX_W-1:0]   ghr_idx;     // history zero-extended to index width

  logic               eu;
  logic [IDX_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  btb_op_e            btb_op;

  logic [RD_PORTS*IDX_W-1:0] rd_pidx;
  logic [RD_PORTS-1:0]       rd_taken;

  logic [31:0] upd_cnt;
  logic [31:0] miss_cnt;

  assign eu      = upd_valid_i & ~stall_i;
  assign upd_idx = IDX_W'(f_idx(64'(upd_addr_i), IDX_W));
  assign upd_tag = TAG_W'(f_tag(64'(upd_addr_i), IDX_W));

  // ---------------------------------------------------------------------------
  // Lookup ports: purely combinational, fully independent of each other.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              match;

    assign addr  = rd_addr_i[k*ADDR_W +: ADDR_W];
    assign idx   = IDX_W'(f_idx(64'(addr), IDX_W));
    assign tag   = TAG_W'(f_tag(64'(addr), IDX_W));
    assign rd_pidx[k*IDX_W +: IDX_W] = idx ^ ghr_idx;

    // A tag compare against an invalidated entry is not a match, so stale
    // targets left behind by a flush never leak out.
    assign match = valid[idx] & (tag_mem[idx] == tag);
    assign rd_hit_o[k] = match & rd_taken[k];
    assign rd_target_o[k*ADDR_W +: ADDR_W] = match ? target_mem[idx] : '0;
  end

  // ---------------------------------------------------------------------------
  // Pattern history table. The update index uses the pre-shift history.
  // ---------------------------------------------------------------------------
  bp_sat_counter_table #(
    .ENTRIES  (ENTRIES),
    .CNT_W    (CNT_W),
    .RD_PORTS (RD_PORTS)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (rd_pidx),
    .rd_taken (rd_taken),
    .we       (eu),
    .wr_idx   (upd_idx ^ ghr_idx),
    .wr_taken (upd_taken_i)
  );

  // ---------------------------------------------------------------------------
  // Global history: shifts in resolved outcomes only.
  // ---------------------------------------------------------------------------
  if (GHR_W > 0) begin : g_ghr
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        ghr <= '0;
      end else if (eu) begin
        // Dropping the top bit of {ghr, taken} gives {ghr[GHR_W-2:0], taken}.
        ghr <= GHR_OW'({ghr, upd_taken_i});
      end
    end
    assign ghr_idx = IDX_W'(ghr);
  end else begin : g_no_ghr
    assign ghr     = '0;
    assign ghr_idx = '0;
  end

  assign ghr_o = ghr;

  // ---------------------------------------------------------------------------
  // BTB write decision. Flush beats a same-cycle allocation; a not-taken
  // update never touches the BTB. Allocation and target refresh on a tag hit
  // are the same write.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves btb_op unassigned,
    // which would otherwise infer a latch.
    btb_op = BTB_HOLD;
    if (flush_i) begin
      btb_op = BTB_FLUSH;
    end else if (eu && upd_taken_i) begin
      btb_op = BTB_WRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
      end
    end else begin
      unique case (btb_op)
        BTB_FLUSH: valid <= '0;
        BTB_WRITE: begin
          valid[upd_idx]      <= 1'b1;
          tag_mem[upd_idx]    <= upd_tag;
          target_mem[upd_idx] <= upd_target_i;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters, saturating at all-ones.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (eu && (upd_cnt != '1)) begin
        upd_cnt <= upd_cnt + 32'd1;
      end
      if (eu && upd_mispredict_i && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign upd_cnt_o  = upd_cnt;
  assign miss_cnt_o = miss_cnt;

endmodule

// File: tb/tb_branch_target_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_target_predictor
// Directed bench for a bimodal instance (GHR_W=0) and a gshare instance
// (GHR_W=2) driven by the same stimulus. Inputs change 1 ns after the rising
// edge; combinational lookups are observed 1 ns later.
// Address map for ENTRIES=16: idx = addr[4:1], tag = addr[31:5]
//   0x104 -> idx 2 tag 8    0x144 -> idx 2 tag 10   0x106 -> idx 3
//   0x108 -> idx 4          0x10C -> idx 6          0x110 -> idx 8
// -----------------------------------------------------------------------------
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [63:0] rd_addr;
  logic        upd_valid;
  logic [31:0] upd_addr;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_mispredict;

  logic [1:0]  hit_b,    hit_g;
  logic [63:0] target_b, target_g;
  logic [0:0]  ghr_b;
  logic [1:0]  ghr_g;
  logic [31:0] upd_cnt_b, upd_cnt_g, miss_cnt_b, miss_cnt_g;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(
    .ENTRIES(16), .ADDR_W(32), .CNT_W(2), .GHR_W(0), .RD_PORTS(2)
  ) dut_b (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .flush_i          (flush),
    .rd_addr_i        (rd_addr),
    .rd_hit_o         (hit_b),
    .rd_target_o      (target_b),
    .upd_valid_i      (upd_valid),
    .upd_addr_i       (upd_addr),
    .upd_target_i     (upd_target),
    .upd_taken_i      (upd_taken),
    .upd_mispredict_i (upd_mispredict),
    .ghr_o            (ghr_b),
    .upd_cnt_o        (upd_cnt_b),
    .miss_cnt_o       (miss_cnt_b)
  );

  branch_target_predictor #(
    .ENTRIES(16), .ADDR_W(32), .CNT_W(2), .GHR_W(2), .RD_PORTS(2)
  ) dut_g (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .flush_i          (flush),
    .rd_addr_i        (rd_addr),
    .rd_hit_o         (hit_g),
    .rd_target_o      (target_g),
    .upd_valid_i      (upd_valid),
    .upd_addr_i       (upd_addr),
    .upd_target_i     (upd_target),
    .upd_taken_i      (upd_taken),
    .upd_mispredict_i (upd_mispredict),
    .ghr_o            (ghr_g),
    .upd_cnt_o        (upd_cnt_g),
    .miss_cnt_o       (miss_cnt_g)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] a0, input logic [31:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  // One effective-or-not update across one clock edge.
  task automatic upd(input logic [31:0] a, input logic [31:0] t,
                     input logic tk, input logic mp);
    upd_valid      = 1'b1;
    upd_addr       = a;
    upd_target     = t;
    upd_taken      = tk;
    upd_mispredict = mp;
    cyc();
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; rd_addr = '0;
    upd_valid = 1'b0; upd_addr = '0; upd_target = '0;
    upd_taken = 1'b0; upd_mispredict = 1'b0;

    // ---- reset ----
    cyc(); cyc();
    rst_n = 1'b1;
    look(32'h100, 32'h100);
    check("reset_hit",      64'(hit_b),      64'h0);
    check("reset_target",   target_b,        64'h0);
    check("reset_upd_cnt",  64'(upd_cnt_b),  64'h0);
    check("reset_miss_cnt", 64'(miss_cnt_b), 64'h0);
    check("reset_ghr_g",    64'(ghr_g),      64'h0);

    // ---- allocate and hit; same-cycle read sees old state ----
    upd_valid = 1'b1; upd_addr = 32'h104; upd_target = 32'h200; upd_taken = 1'b1;
    look(32'h104, 32'h106);
    check("same_cycle_hit", 64'(hit_b), 64'h0);
    cyc();
    upd_valid = 1'b0;
    look(32'h104, 32'h106);
    check("alloc_hit",    64'(hit_b),      64'h1);   // counter 1->2
    check("alloc_target", target_b[31:0], 64'h200);
    check("alloc_cnt",    64'(upd_cnt_b),  64'd1);

    // ---- saturation ----
    repeat (5) upd(32'h104, 32'h200, 1'b1, 1'b0);    // counter pinned at 3
    upd(32'h104, 32'h200, 1'b0, 1'b1);                // 3->2, one mispredict
    look(32'h104, 32'h104);
    check("sat_dec_hit",  64'(hit_b),      64'h3);
    check("sat_miss_cnt", 64'(miss_cnt_b), 64'd1);
    repeat (3) upd(32'h104, 32'h200, 1'b0, 1'b0);    // 2->1->0->0
    look(32'h104, 32'h104);
    check("floor_hit",    64'(hit_b),          64'h0);
    check("floor_target", 64'(target_b[31:0]), 64'h200);
    check("floor_cnt",    64'(upd_cnt_b),      64'd10);
    upd(32'h104, 32'h200, 1'b1, 1'b0);                // 0->1, no wrap to 3
    look(32'h104, 32'h104);
    check("no_wrap_hit", 64'(hit_b), 64'h0);
    upd(32'h104, 32'h200, 1'b1, 1'b0);                // 1->2
    look(32'h104, 32'h104);
    check("rise_hit", 64'(hit_b), 64'h3);

    // ---- alias replacement and target refresh ----
    upd(32'h144, 32'h300, 1'b1, 1'b0);                // counter 2->3
    look(32'h104, 32'h144);
    check("alias_hit",     64'(hit_b),           64'h2);
    check("alias_tgt_old", 64'(target_b[31:0]),  64'h0);
    check("alias_tgt_new", 64'(target_b[63:32]), 64'h300);
    upd(32'h144, 32'h340, 1'b1, 1'b0);
    look(32'h104, 32'h144);
    check("refresh_tgt", 64'(target_b[63:32]), 64'h340);

    // ---- not-taken never allocates ----
    upd(32'h108, 32'h800, 1'b0, 1'b0);
    look(32'h108, 32'h144);
    check("nt_hit",    64'(hit_b),          64'h2);
    check("nt_target", 64'(target_b[31:0]), 64'h0);
    check("nt_cnt",    64'(upd_cnt_b),      64'd15);

    // ---- stall holds off the update ----
    stall = 1'b1; upd_valid = 1'b1; upd_addr = 32'h10C;
    upd_target = 32'h500; upd_taken = 1'b1;
    repeat (3) cyc();
    look(32'h10C, 32'h10C);
    check("stall_cnt",    64'(upd_cnt_b), 64'd15);
    check("stall_hit",    64'(hit_b),     64'h0);
    check("stall_target", target_b,       64'h0);
    stall = 1'b0;
    cyc();
    upd_valid = 1'b0;
    look(32'h10C, 32'h10C);
    check("unstall_hit",    64'(hit_b),          64'h3);
    check("unstall_target", 64'(target_b[31:0]), 64'h500);
    check("unstall_cnt",    64'(upd_cnt_b),      64'd16);

    // ---- flush beats allocation, PHT and counters still move ----
    flush = 1'b1;
    upd(32'h110, 32'h600, 1'b1, 1'b0);                // idx 8 counter 1->2
    flush = 1'b0;
    look(32'h110, 32'h144);
    check("flush_hit",    64'(hit_b),          64'h0);
    check("flush_target", 64'(target_b[31:0]), 64'h0);
    check("flush_cnt",    64'(upd_cnt_b),      64'd17);
    upd(32'h110, 32'h600, 1'b1, 1'b0);                // 2->3, allocate
    upd(32'h110, 32'h600, 1'b0, 1'b0);                // 3->2, still taken
    look(32'h110, 32'h110);
    check("post_flush_hit",    64'(hit_b),          64'h3);
    check("post_flush_target", 64'(target_b[31:0]), 64'h600);
    check("bimodal_ghr",       64'(ghr_b),          64'h0);

    // ---- reset during an update discards it ----
    rst_n = 1'b0; upd_valid = 1'b1; upd_addr = 32'h104;
    upd_target = 32'h200; upd_taken = 1'b1;
    cyc(); cyc();
    upd_valid = 1'b0; rst_n = 1'b1;
    look(32'h104, 32'h104);
    check("rst_upd_hit_b", 64'(hit_b),     64'h0);
    check("rst_upd_hit_g", 64'(hit_g),     64'h0);
    check("rst_upd_cnt_g", 64'(upd_cnt_g), 64'd0);

    // ---- gshare ----
    // pidx = idx ^ ghr(pre-shift); idx of 0x104 is 2.
    upd(32'h104, 32'h200, 1'b1, 1'b0);   // ghr 00: pidx 2 1->2, ghr 01
    upd(32'h104, 32'h200, 1'b1, 1'b0);   // ghr 01: pidx 3 1->2, ghr 11
    upd(32'h104, 32'h200, 1'b0, 1'b0);   // ghr 11: pidx 1 1->0, ghr 10
    look(32'h104, 32'h106);
    check("gs_ghr_10",   64'(ghr_g),          64'h2);
    check("gs_upd_cnt",  64'(upd_cnt_g),      64'd3);
    check("gs_hit",      64'(hit_g),          64'h0);  // pidx 0 still 1
    check("gs_target",   64'(target_g[31:0]), 64'h200);
    check("gs_bimodal",  64'(hit_b),          64'h1);  // idx 2 counter 2
    upd(32'h104, 32'h200, 1'b1, 1'b0);   // ghr 10: pidx 0 1->2, ghr 01
    upd(32'h108, 32'h800, 1'b0, 1'b0);   // ghr 01: pidx 5 1->0, ghr 10
    look(32'h104, 32'h108);
    check("gs_ghr_back", 64'(ghr_g), 64'h2);
    check("gs_pidx0",    64'(hit_g), 64'h1);          // pidx 0 now 2

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
